floo_xy_route_stage: RTL and testbench

FLOO_XY_ROUTE_STAGE -- requirements
Module: floo_xy_route_stage

---
 rtl/floo_xy_route_stage.sv | 114 +++++++++++
 tb/tb_floo_xy_route_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/floo_xy_route_stage.sv
// XY dimension-ordered route computation stage with a 2-entry output FIFO.
// Head flits are routed from dst_i; body flits inherit the head's route.
module floo_xy_route_stage #(
    parameter int unsigned XYWidth   = 3,
    parameter int unsigned DataWidth = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2*XYWidth-1:0]   xy_id_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*XYWidth-1:0]   dst_i,
    input  logic                   last_i,
    input  logic [DataWidth-1:0]   data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2:0]             route_o,
    output logic                   last_o,
    output logic [DataWidth-1:0]   data_o
);

    localparam logic [0:0] StHead = 1'b0;
    localparam logic [0:0] StBody = 1'b1;

    localparam logic [2:0] RouteEject = 3'd0;
    localparam logic [2:0] RouteNorth = 3'd1;
    localparam logic [2:0] RouteEast  = 3'd2;
    localparam logic [2:0] RouteSouth = 3'd3;
    localparam logic [2:0] RouteWest  = 3'd4;

    logic [XYWidth-1:0]   local_x, local_y, dst_x, dst_y;
    logic [2:0]           head_route, in_route;
    logic [0:0]           state_q;
    logic [2:0]           latched_q;
    logic [2:0]           route_mem [2];
    logic                 last_mem  [2];
    logic [DataWidth-1:0] data_mem  [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q;
    logic                 push, pop;

    assign local_x = xy_id_i[XYWidth-1:0];
    assign local_y = xy_id_i[2*XYWidth-1:XYWidth];
    assign dst_x   = dst_i[XYWidth-1:0];
    assign dst_y   = dst_i[2*XYWidth-1:XYWidth];

    // X is resolved completely before Y is considered
    always_comb begin
        head_route = RouteEject;
        if (dst_x > local_x) begin
            head_route = RouteEast;
        end else if (dst_x < local_x) begin
            head_route = RouteWest;
        end else if (dst_y > local_y) begin
            head_route = RouteNorth;
        end else if (dst_y < local_y) begin
            head_route = RouteSouth;
        end
    end

    always_comb begin
        in_route = head_route;
        if (state_q == StBody) begin
            in_route = latched_q;
        end
    end

    assign ready_o = !rst_i && (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    assign route_o = route_mem[rd_ptr_q];
    assign last_o  = last_mem[rd_ptr_q];
    assign data_o  = data_mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StHead;
            latched_q    <= RouteEject;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            route_mem[0] <= '0;
            route_mem[1] <= '0;
            last_mem[0]  <= 1'b0;
            last_mem[1]  <= 1'b0;
            data_mem[0]  <= '0;
            data_mem[1]  <= '0;
        end else begin
            if (push) begin
                route_mem[wr_ptr_q] <= in_route;
                last_mem[wr_ptr_q]  <= last_i;
                data_mem[wr_ptr_q]  <= data_i;
                wr_ptr_q            <= ~wr_ptr_q;
                if (state_q == StHead && !last_i) begin
                    state_q   <= StBody;
                    latched_q <= head_route;
                end else if (state_q == StBody && last_i) begin
                    state_q <= StHead;
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_floo_xy_route_stage.sv
// Directed and randomized checks of floo_xy_route_stage against a
// queue-based reference model of packet routing and buffering.
module tb_floo_xy_route_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  xy;
    logic        valid;
    logic        ready_o;
    logic [5:0]  dst;
    logic        last;
    logic [63:0] data;
    logic        valid_o;
    logic        ready;
    logic [2:0]  route_o;
    logic        last_o;
    logic [63:0] data_o;

    floo_xy_route_stage #(
        .XYWidth  (3),
        .DataWidth(64)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .xy_id_i (xy),
        .valid_i (valid),
        .ready_o (ready_o),
        .dst_i   (dst),
        .last_i  (last),
        .data_i  (data),
        .valid_o (valid_o),
        .ready_i (ready),
        .route_o (route_o),
        .last_o  (last_o),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  r;
        logic        l;
        logic [63:0] d;
    } ent_t;

    ent_t q[$];
    bit   in_body;
    int   latched;
    bit   fresh;
    int   n_chk;
    int   n_fail;

    // Destination relative to the local node decides the exit port, X first
    function automatic int ref_route(input int mx, input int my, input int dx, input int dy);
        if (dx > mx) return 2;
        if (dx < mx) return 4;
        if (dy > my) return 1;
        if (dy < my) return 3;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit   in_acc, out_acc;
        int   r;
        ent_t e;
        @(negedge clk);
        chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() > 0});
        chk("ready_o", {63'd0, ready_o}, {63'd0, (!rst && q.size() < 2)});
        if (q.size() > 0) begin
            chk("data_o",  data_o,           q[0].d);
            chk("route_o", {61'd0, route_o}, {61'd0, q[0].r});
            chk("last_o",  {63'd0, last_o},  {63'd0, q[0].l});
        end else if (fresh) begin
            chk("idle_data",  data_o,           64'd0);
            chk("idle_route", {61'd0, route_o}, 64'd0);
            chk("idle_last",  {63'd0, last_o},  64'd0);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            in_body = 0;
            latched = 0;
            fresh   = 1;
        end else begin
            in_acc  = valid && (q.size() < 2);
            out_acc = (q.size() > 0) && ready;
            if (out_acc) void'(q.pop_front());
            if (in_acc) begin
                r = in_body ? latched
                            : ref_route(int'(xy[2:0]), int'(xy[5:3]), int'(dst[2:0]), int'(dst[5:3]));
                e.r = r[2:0];
                e.l = last;
                e.d = data;
                q.push_back(e);
                fresh = 0;
                if (!in_body) latched = r;
                in_body = !last;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] d, input logic l,
                         input logic [63:0] dat, input logic rdy);
        valid = v;
        dst   = d;
        last  = l;
        data  = dat;
        ready = rdy;
        cycle();
    endtask

    task automatic do_reset(input logic [5:0] id);
        xy  = id;
        rst = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        xy     = {3'd1, 3'd1};
        valid  = 1'b0;
        dst    = '0;
        last   = 1'b0;
        data   = '0;
        ready  = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        in_body = 0;
        latched = 0;
        fresh   = 1;

        // Reset holds: outputs zero, not ready
        drive(1'b1, 6'd5, 1'b1, 64'hDEAD, 1'b1);
        rst = 1'b0;

        // Single-flit packets: East then Eject
        drive(1'b1, {3'd1, 3'd3}, 1'b1, 64'h11, 1'b1);
        chk("req032_east", {61'd0, route_o}, 64'd2);
        drive(1'b1, {3'd1, 3'd1}, 1'b1, 64'h12, 1'b1);
        chk("req032_eject", {61'd0, route_o}, 64'd0);
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);

        // 3-flit packet: body flits keep the head's South route
        do_reset({3'd2, 3'd2});
        drive(1'b1, {3'd0, 3'd2}, 1'b0, 64'h21, 1'b1);
        chk("req033_head", {61'd0, route_o}, 64'd3);
        drive(1'b1, {3'd7, 3'd7}, 1'b0, 64'h22, 1'b1);
        chk("req033_body", {61'd0, route_o}, 64'd3);
        drive(1'b1, {3'd7, 3'd7}, 1'b1, 64'h23, 1'b1);
        chk("req033_tail", {61'd0, route_o}, 64'd3);
        drive(1'b1, {3'd2, 3'd7}, 1'b1, 64'h24, 1'b1);
        chk("req033_next_head", {61'd0, route_o}, 64'd2);

        // Backpressure: two accepted, third refused, then drained in order
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);
        drive(1'b1, {3'd2, 3'd3}, 1'b1, 64'hA, 1'b0);
        drive(1'b1, {3'd2, 3'd3}, 1'b1, 64'hB, 1'b0);
        drive(1'b1, {3'd2, 3'd3}, 1'b1, 64'hC, 1'b0);
        drive(1'b1, {3'd2, 3'd3}, 1'b1, 64'hC, 1'b0);
        drive(1'b1, {3'd2, 3'd3}, 1'b1, 64'hC, 1'b1);
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);

        // Streaming at one flit per cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, {3'd1, 3'd0}, 1'b1, 64'h100 + 64'(i), 1'b1);
            chk("stream_valid", {63'd0, valid_o}, 64'd1);
        end
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);

        // Reset mid-packet: next flit is routed as a head
        drive(1'b1, {3'd2, 3'd0}, 1'b0, 64'h31, 1'b1);
        rst = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);
        rst = 1'b0;
        drive(1'b1, {3'd3, 3'd2}, 1'b1, 64'h32, 1'b1);
        chk("req036_head", {61'd0, route_o}, 64'd1);

        // X takes priority over Y
        do_reset({3'd0, 3'd7});
        drive(1'b1, {3'd7, 3'd0}, 1'b1, 64'h41, 1'b1);
        chk("req037_west", {61'd0, route_o}, 64'd4);
        drive(1'b0, 6'd0, 1'b0, 64'd0, 1'b1);

        // Randomized traffic with occasional resets
        do_reset({3'd3, 3'd4});
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            valid = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 3) != 0);
            last  = ($urandom_range(0, 2) == 0);
            dst   = 6'($urandom);
            data  = {$urandom, $urandom};
            cycle();
        end
        rst   = 1'b0;
        valid = 1'b0;
        ready = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
